// File: rtl/db_left_ctrl.sv
// Left-neighbour pixel controller: streams 16 stored left-edge words out of the
// line RAM (LOAD), then writes the current LCU's right-edge words back (STORE).
module db_left_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  first_lcu_i,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  rd_ready_i,
    input  logic                  wr_valid_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cen_o,
    output logic                  ren_o,
    output logic                  wen_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(1 << ADDR_WIDTH);
    localparam logic [CW-1:0] LAST  = CW'((1 << ADDR_WIDTH) - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         rd_issue_cnt, rd_beat_cnt, wr_cnt;
    logic [1:0]            occ, occ_left;
    logic                  rd_inflight;
    logic [DATA_WIDTH-1:0] buf_head, buf_tail;
    logic                  rd_pop, rd_issue, wr_fire, enter;

    assign rd_valid_o = (state == LOAD) && (occ != 2'd0);
    assign rd_data_o  = buf_head;
    assign wr_ready_o = (state == STORE);
    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DONE);
    assign ren_o      = ~rd_inflight;

    assign rd_pop  = rd_valid_o && rd_ready_i;
    assign wr_fire = (state == STORE) && wr_valid_i;

    // The word leaving the buffer this cycle frees its slot for a new issue,
    // which is what sustains one beat per cycle with ready held high.
    assign occ_left = occ - {1'b0, rd_pop};
    assign rd_issue = (state == LOAD) && (rd_issue_cnt < DEPTH) &&
                      ((occ_left + {1'b0, rd_inflight}) < 2'd2);

    assign enter = (state_nxt != state) && (state_nxt == LOAD || state_nxt == STORE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = first_lcu_i ? STORE : LOAD;
            LOAD:    if (rd_pop && rd_beat_cnt == LAST) state_nxt = STORE;
            STORE:   if (wr_fire && wr_cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cen_o      = 1'b1;
        wen_o      = 1'b1;
        addr_o     = '0;
        ram_data_o = '0;
        if (rd_issue) begin
            cen_o  = 1'b0;
            addr_o = rd_issue_cnt[ADDR_WIDTH-1:0];
        end else if (wr_fire) begin
            cen_o      = 1'b0;
            wen_o      = 1'b0;
            addr_o     = wr_cnt[ADDR_WIDTH-1:0];
            ram_data_o = wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rd_issue_cnt <= '0;
            rd_beat_cnt  <= '0;
            wr_cnt       <= '0;
            rd_inflight  <= 1'b0;
            occ          <= 2'd0;
        end else begin
            state <= state_nxt;
            if (enter) begin
                rd_issue_cnt <= '0;
                rd_beat_cnt  <= '0;
                wr_cnt       <= '0;
                rd_inflight  <= 1'b0;
                occ          <= 2'd0;
            end else begin
                if (rd_issue) rd_issue_cnt <= rd_issue_cnt + ONE;
                if (rd_pop)   rd_beat_cnt  <= rd_beat_cnt + ONE;
                if (wr_fire)  wr_cnt       <= wr_cnt + ONE;
                rd_inflight <= rd_issue;
                case ({rd_inflight, rd_pop})
                    2'b10:   occ <= occ + 2'd1;
                    2'b01:   occ <= occ - 2'd1;
                    default: occ <= occ;
                endcase
            end
        end
    end

    // Two-entry FIFO kept as head/tail registers so the head drives rd_data_o directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_head <= '0;
            buf_tail <= '0;
        end else begin
            case ({rd_inflight, rd_pop})
                2'b10: begin
                    if (occ == 2'd0) buf_head <= ram_data_i;
                    else             buf_tail <= ram_data_i;
                end
                2'b01: buf_head <= buf_tail;
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf_head <= ram_data_i;
                    end else begin
                        buf_head <= buf_tail;
                        buf_tail <= ram_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_db_left_ctrl.sv
// Directed bench for db_left_ctrl with a small synchronous RAM model on the port.
module tb_db_left_ctrl;

    localparam int DW = 128;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          first_lcu_i = 1'b0;
    logic          rd_valid_o;
    logic [DW-1:0] rd_data_o;
    logic          rd_ready_i = 1'b0;
    logic          wr_valid_i = 1'b0;
    logic [DW-1:0] wr_data_i = '0;
    logic          wr_ready_o, busy_o, done_o, cen_o, ren_o, wen_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] ram_data_o, ram_data_i;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] ram_q = '0;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    db_left_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .first_lcu_i(first_lcu_i),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
        .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
        .busy_o(busy_o), .done_o(done_o), .cen_o(cen_o), .ren_o(ren_o), .wen_o(wen_o),
        .addr_o(addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!cen_o) begin
            if (!wen_o) mem[addr_o] <= ram_data_o;
            else        ram_q <= mem[addr_o];
        end
    end
    assign ram_data_i = ram_q;

    always @(negedge clk) if (rst_n && done_o === 1'b1) done_cnt++;

    task automatic preload();
        for (int k = 0; k < 16; k++) mem[k] = DW'(k * 17);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({rd_valid_o, wr_ready_o, busy_o, done_o, cen_o, ren_o, wen_o} !== 7'b0000111 ||
            addr_o !== '0 || rd_data_o !== '0 || ram_data_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got ctl=%b addr=%h, required ctl=0000111 addr=0",
                     {rd_valid_o, wr_ready_o, busy_o, done_o, cen_o, ren_o, wen_o}, addr_o);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (busy_o !== 1'b0 || cen_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got busy=%b cen=%b, required busy=0 cen=1", busy_o, cen_o);
        end
    endtask

    task automatic test_load();
        preload();
        rd_ready_i = 1'b1; first_lcu_i = 1'b0; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0; #1;
        checks++;
        if (cen_o !== 1'b0 || wen_o !== 1'b1 || addr_o !== 4'd0 || busy_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_first_issue: got cen=%b wen=%b addr=%h busy=%b, required 0 1 0 1",
                     cen_o, wen_o, addr_o, busy_o);
        end
        @(negedge clk); #1;
        checks++;
        if (rd_valid_o !== 1'b0 || ren_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_capture_cycle: got valid=%b ren=%b, required valid=0 ren=0", rd_valid_o, ren_o);
        end
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++;
            if (rd_valid_o !== 1'b1 || rd_data_o !== DW'(k * 17)) begin
                errors++;
                $display("[TB] FAIL load_beat%0d: got valid=%b data=%h, required valid=1 data=%h",
                         k, rd_valid_o, rd_data_o, DW'(k * 17));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (wr_ready_o !== 1'b1 || rd_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_to_store: got wr_ready=%b rd_valid=%b, required 1 0", wr_ready_o, rd_valid_o);
        end
    endtask

    // Entered at a negedge while the DUT sits in STORE.
    task automatic test_store(input int base);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 16; k++) begin
            wr_valid_i = 1'b1; wr_data_i = DW'(base + k); #1;
            checks++;
            if (cen_o !== 1'b0 || wen_o !== 1'b0 || addr_o !== 4'(k) || ram_data_o !== DW'(base + k)) begin
                errors++;
                $display("[TB] FAIL store_beat%0d: got cen=%b wen=%b addr=%h data=%h, required 0 0 %h %h",
                         k, cen_o, wen_o, addr_o, ram_data_o, 4'(k), DW'(base + k));
            end
            @(negedge clk);
        end
        wr_valid_i = 1'b0; #1;
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b1 || wr_ready_o !== 1'b0 || cen_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL store_done: got done=%b busy=%b wr_ready=%b cen=%b, required 1 1 0 1",
                     done_o, busy_o, wr_ready_o, cen_o);
        end
        @(negedge clk); #1;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || done_cnt - d0 !== 1) begin
            errors++;
            $display("[TB] FAIL store_idle: got done=%b busy=%b pulses=%0d, required 0 0 1",
                     done_o, busy_o, done_cnt - d0);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (mem[k] !== DW'(base + k)) begin
                errors++;
                $display("[TB] FAIL ram_word%0d: got %h, required %h", k, mem[k], DW'(base + k));
            end
        end
    endtask

    task automatic test_first_lcu();
        first_lcu_i = 1'b1; start_i = 1'b1; #1;
        checks++;
        if (cen_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_start_cycle: got cen=%b, required 1", cen_o);
        end
        @(negedge clk); start_i = 1'b0; first_lcu_i = 1'b0; #1;
        checks++;
        if (wr_ready_o !== 1'b1 || cen_o !== 1'b1 || ren_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_enters_store: got wr_ready=%b cen=%b ren=%b, required 1 1 1",
                     wr_ready_o, cen_o, ren_o);
        end
        test_store(32'h200);
    endtask

    task automatic test_back_to_back_backpressure();
        logic [3:0]    pat;
        logic [DW-1:0] held;
        logic          stalled;
        int            issued, beats;
        pat = 4'b1001;
        held = '0; stalled = 1'b0; issued = 0; beats = 0;
        preload();
        first_lcu_i = 1'b0; start_i = 1'b1; rd_ready_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int i = 0; i < 200 && beats < 16; i++) begin
            rd_ready_i = pat[i % 4]; #1;
            if (stalled) begin
                checks++;
                if (rd_valid_o !== 1'b1 || rd_data_o !== held) begin
                    errors++;
                    $display("[TB] FAIL bp_hold: got valid=%b data=%h, required 1 %h", rd_valid_o, rd_data_o, held);
                end
            end
            if (cen_o === 1'b0 && wen_o === 1'b1) begin
                checks++;
                if (addr_o !== 4'(issued)) begin
                    errors++;
                    $display("[TB] FAIL bp_issue_addr: got %h, required %h", addr_o, 4'(issued));
                end
                issued++;
            end
            if (rd_valid_o === 1'b1 && rd_ready_i) begin
                checks++;
                if (rd_data_o !== DW'(beats * 17)) begin
                    errors++;
                    $display("[TB] FAIL bp_beat%0d: got %h, required %h", beats, rd_data_o, DW'(beats * 17));
                end
                beats++;
            end
            checks++;
            if (issued - beats > 2) begin
                errors++;
                $display("[TB] FAIL bp_outstanding: got %0d, required <=2", issued - beats);
            end
            stalled = (rd_valid_o === 1'b1) && !rd_ready_i;
            held = rd_data_o;
            @(negedge clk);
        end
        rd_ready_i = 1'b1; #1;
        checks++;
        if (beats !== 16 || issued !== 16 || wr_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_complete: got beats=%0d issued=%0d wr_ready=%b, required 16 16 1",
                     beats, issued, wr_ready_o);
        end
        test_store(32'h300);
    endtask

    task automatic test_start_in_store();
        int d0;
        first_lcu_i = 1'b1; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0; first_lcu_i = 1'b0;
        d0 = done_cnt;
        for (int k = 0; k < 16; k++) begin
            wr_valid_i = 1'b1; wr_data_i = DW'(32'h400 + k);
            start_i = (k == 5);
            @(negedge clk);
        end
        wr_valid_i = 1'b0; start_i = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (busy_o !== 1'b0 || cen_o !== 1'b1 || done_cnt - d0 !== 1) begin
            errors++;
            $display("[TB] FAIL start_in_store: got busy=%b cen=%b pulses=%0d, required 0 1 1",
                     busy_o, cen_o, done_cnt - d0);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (mem[k] !== DW'(32'h400 + k)) begin
                errors++;
                $display("[TB] FAIL sis_word%0d: got %h, required %h", k, mem[k], DW'(32'h400 + k));
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int d0;
        preload();
        d0 = done_cnt;
        first_lcu_i = 1'b0; start_i = 1'b1; rd_ready_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== DW'(7 * 17)) begin
            errors++;
            $display("[TB] FAIL mid_load_beat7: got valid=%b data=%h, required 1 %h", rd_valid_o, rd_data_o, DW'(7 * 17));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_valid_o, wr_ready_o, busy_o, done_o, cen_o, ren_o, wen_o} !== 7'b0000111 ||
            addr_o !== '0 || rd_data_o !== '0 || ram_data_o !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got ctl=%b addr=%h data=%h, required ctl=0000111 addr=0 data=0",
                     {rd_valid_o, wr_ready_o, busy_o, done_o, cen_o, ren_o, wen_o}, addr_o, rd_data_o);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (busy_o !== 1'b0 || done_cnt !== d0) begin
            errors++;
            $display("[TB] FAIL abort_idle: got busy=%b pulses=%0d, required 0 0", busy_o, done_cnt - d0);
        end
        start_i = 1'b1;
        @(negedge clk); start_i = 1'b0; #1;
        checks++;
        if (cen_o !== 1'b0 || wen_o !== 1'b1 || addr_o !== 4'd0) begin
            errors++;
            $display("[TB] FAIL restart_addr: got cen=%b wen=%b addr=%h, required 0 1 0", cen_o, wen_o, addr_o);
        end
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== '0) begin
            errors++;
            $display("[TB] FAIL restart_beat0: got valid=%b data=%h, required 1 0", rd_valid_o, rd_data_o);
        end
        repeat (16) @(negedge clk);
        test_store(32'h500);
    endtask

    initial begin
        test_reset();
        test_load();
        test_store(32'h100);
        test_first_lcu();
        test_back_to_back_backpressure();
        test_start_in_store();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
